cpu_5bit: RTL and testbench

CPU_5BIT -- requirements
Module: cpu_5bit

---
 rtl/cpu_5bit.sv | 141 ++++++++++++++
 tb/tb_cpu_5bit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_5bit.sv
// Single-cycle 5-bit CPU: 8 x 11-bit program/data RAM, four 5-bit registers, G/E flags,
// a registered output port and an external input that can stand in for R2.
module cpu_5bit (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_Enable,
  input  logic        RAM_Write_Enable,
  input  logic [2:0]  RAM_Write_Address,
  input  logic [10:0] RAM_Write_Data,
  input  logic [4:0]  InD,
  input  logic        InE,
  output logic [4:0]  OutD,
  output logic [2:0]  PC,
  output logic [10:0] PI,
  output logic [4:0]  REG0,
  output logic [4:0]  REG1,
  output logic [4:0]  REG2,
  output logic [4:0]  REG3,
  output logic [10:0] RAM0,
  output logic [10:0] RAM1,
  output logic [10:0] RAM2,
  output logic [10:0] RAM3,
  output logic [10:0] RAM4,
  output logic [10:0] RAM5,
  output logic [10:0] RAM6,
  output logic [10:0] RAM7
);

  localparam int unsigned DW    = 5;
  localparam int unsigned AW    = 3;
  localparam int unsigned IW    = 11;
  localparam int unsigned NREG  = 4;
  localparam int unsigned NWORD = 8;

  typedef enum logic [3:0] {
    OP_NOP = 4'b0000, OP_MOV = 4'b0001, OP_JMP = 4'b0010, OP_JG  = 4'b0011,
    OP_JE  = 4'b0100, OP_JNE = 4'b0101, OP_ROL = 4'b0110, OP_ROR = 4'b0111,
    OP_CMP = 4'b1000, OP_OUT = 4'b1001, OP_SUB = 4'b1010, OP_ADD = 4'b1011,
    OP_AND = 4'b1100, OP_OR  = 4'b1101, OP_LD  = 4'b1110, OP_ST  = 4'b1111
  } op_e;

  logic [IW-1:0] mem  [NWORD];
  logic [DW-1:0] regs [NREG];
  logic          g_flag, e_flag;

  op_e           op;
  logic [1:0]    rd, rs;
  logic [2:0]    imm3, target, rot_amt;
  logic [DW-1:0] rd_val, rs_val;

  logic [AW-1:0] pc_nxt;
  logic          wr_en, flag_en, out_en, st_en;
  logic [DW-1:0] wr_val;
  logic          g_nxt, e_nxt;
  logic [AW-1:0] st_addr;
  logic [IW-1:0] st_data;

  assign PI     = mem[PC];
  assign op     = op_e'(PI[10:7]);
  assign rd     = PI[6:5];
  assign rs     = PI[4:3];
  assign imm3   = PI[2:0];
  assign target = PI[6:4];

  // With InE set, R2 reads see the live input rather than the stored value
  assign rd_val  = (InE && rd == 2'd2) ? InD : regs[rd];
  assign rs_val  = (InE && rs == 2'd2) ? InD : regs[rs];
  assign rot_amt = (imm3 >= 3'd5) ? imm3 - 3'd5 : imm3;

  // Instruction decode and next-state computation
  always_comb begin
    pc_nxt  = PC + AW'(1);
    wr_en   = 1'b0;
    wr_val  = rd_val;
    flag_en = 1'b0;
    g_nxt   = g_flag;
    e_nxt   = e_flag;
    out_en  = 1'b0;
    st_en   = 1'b0;
    st_addr = rs_val[2:0];
    st_data = {6'b0, rd_val};
    case (op)
      OP_NOP: ;
      OP_MOV: begin wr_en = 1'b1; wr_val = rs_val; end
      OP_JMP: pc_nxt = target;
      OP_JG:  if (g_flag)  pc_nxt = target;
      OP_JE:  if (e_flag)  pc_nxt = target;
      OP_JNE: if (!e_flag) pc_nxt = target;
      OP_ROL: begin wr_en = 1'b1; wr_val = DW'(({rd_val, rd_val} << rot_amt) >> DW); end
      OP_ROR: begin wr_en = 1'b1; wr_val = DW'({rd_val, rd_val} >> rot_amt); end
      OP_CMP: begin flag_en = 1'b1; g_nxt = (rd_val > rs_val); e_nxt = (rd_val == rs_val); end
      OP_OUT: out_en = 1'b1;
      OP_SUB: begin wr_en = 1'b1; wr_val = rd_val - rs_val; end
      OP_ADD: begin wr_en = 1'b1; wr_val = rd_val + rs_val; end
      OP_AND: begin wr_en = 1'b1; wr_val = rd_val & rs_val; end
      OP_OR:  begin wr_en = 1'b1; wr_val = rd_val | rs_val; end
      OP_LD:  begin wr_en = 1'b1; wr_val = mem[rs_val[2:0]][DW-1:0]; end
      OP_ST:  st_en = 1'b1;
      default: ;
    endcase
  end

  // State update; later assignments give the external write and instruction write priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC     <= '0;
      OutD   <= '0;
      g_flag <= 1'b0;
      e_flag <= 1'b0;
      regs   <= '{default: '0};
      mem    <= '{default: '0};
    end else begin
      if (InE) regs[2] <= InD;
      if (PC_Enable) begin
        PC <= pc_nxt;
        if (wr_en) regs[rd] <= wr_val;
        if (flag_en) begin
          g_flag <= g_nxt;
          e_flag <= e_nxt;
        end
        if (out_en) OutD <= rs_val;
        if (st_en)  mem[st_addr] <= st_data;
      end
      if (RAM_Write_Enable) mem[RAM_Write_Address] <= RAM_Write_Data;
    end
  end

  assign REG0 = regs[0];
  assign REG1 = regs[1];
  assign REG2 = regs[2];
  assign REG3 = regs[3];
  assign RAM0 = mem[0];
  assign RAM1 = mem[1];
  assign RAM2 = mem[2];
  assign RAM3 = mem[3];
  assign RAM4 = mem[4];
  assign RAM5 = mem[5];
  assign RAM6 = mem[6];
  assign RAM7 = mem[7];

endmodule

// File: tb/tb_cpu_5bit.sv
// Scoreboard bench for cpu_5bit: directed programs push expected values, a monitor compares.
module tb_cpu_5bit;

  logic        clk = 1'b0;
  logic        reset;
  logic        PC_Enable, RAM_Write_Enable, InE;
  logic [2:0]  RAM_Write_Address;
  logic [10:0] RAM_Write_Data;
  logic [4:0]  InD;
  logic [4:0]  OutD, REG0, REG1, REG2, REG3;
  logic [2:0]  PC;
  logic [10:0] PI, RAM0, RAM1, RAM2, RAM3, RAM4, RAM5, RAM6, RAM7;

  cpu_5bit dut (
    .clk(clk), .reset(reset), .PC_Enable(PC_Enable),
    .RAM_Write_Enable(RAM_Write_Enable), .RAM_Write_Address(RAM_Write_Address),
    .RAM_Write_Data(RAM_Write_Data), .InD(InD), .InE(InE), .OutD(OutD), .PC(PC), .PI(PI),
    .REG0(REG0), .REG1(REG1), .REG2(REG2), .REG3(REG3),
    .RAM0(RAM0), .RAM1(RAM1), .RAM2(RAM2), .RAM3(RAM3),
    .RAM4(RAM4), .RAM5(RAM5), .RAM6(RAM6), .RAM7(RAM7)
  );

  always #5 clk = ~clk;

  localparam int S_PC = 0, S_R0 = 1, S_R1 = 2, S_R2 = 3, S_R3 = 4, S_OUT = 5, S_RAM = 6, S_PI = 14;

  typedef struct {
    int          sel;
    logic [10:0] exp;
    string       name;
  } chk_t;

  chk_t sb_q[$];
  event mon_ev;
  int   checks = 0;
  int   failures = 0;

  function automatic logic [10:0] probe(input int sel);
    case (sel)
      S_PC:      return 11'(PC);
      S_R0:      return 11'(REG0);
      S_R1:      return 11'(REG1);
      S_R2:      return 11'(REG2);
      S_R3:      return 11'(REG3);
      S_OUT:     return 11'(OutD);
      S_RAM + 0: return RAM0;
      S_RAM + 1: return RAM1;
      S_RAM + 2: return RAM2;
      S_RAM + 3: return RAM3;
      S_RAM + 4: return RAM4;
      S_RAM + 5: return RAM5;
      S_RAM + 6: return RAM6;
      S_RAM + 7: return RAM7;
      S_PI:      return PI;
      default:   return 11'h7ff;
    endcase
  endfunction

  // Monitor: on each presentation of DUT outputs, drain all pending expectations
  initial begin
    chk_t c;
    logic [10:0] act;
    forever begin
      @(mon_ev);
      while (sb_q.size() > 0) begin
        c   = sb_q.pop_front();
        act = probe(c.sel);
        checks++;
        if (act !== c.exp) begin
          failures++;
          $display("FAIL %s: got %0d expected %0d", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic expect_val(input int sel, input logic [10:0] v, input string name);
    sb_q.push_back('{sel: sel, exp: v, name: name});
  endtask

  task automatic present();
    -> mon_ev;
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_cleared(input string tag);
    expect_val(S_PC, 11'd0, {tag, "_pc"});
    expect_val(S_OUT, 11'd0, {tag, "_outd"});
    for (int i = 0; i < 4; i++) expect_val(S_R0 + i, 11'd0, $sformatf("%s_reg%0d", tag, i));
    for (int i = 0; i < 8; i++) expect_val(S_RAM + i, 11'd0, $sformatf("%s_ram%0d", tag, i));
  endtask

  logic [10:0] prog1 [8];
  logic [10:0] prog2 [7];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prog1 = '{11'b11100110000, 11'b10110010000, 11'b10000001000, 11'b00110010000,
              11'b01100000010, 11'b10111100000, 11'b00000000000, 11'b00000000011};
    prog2 = '{11'b00010110000, 11'b10010001000, 11'b11110111000, 11'b01110100001,
              11'b10100001000, 11'b10000101000, 11'b01000000000};

    reset = 1'b0; PC_Enable = 1'b0; RAM_Write_Enable = 1'b0;
    RAM_Write_Address = '0; RAM_Write_Data = '0; InD = '0; InE = 1'b0;
    #12;
    expect_cleared("por");
    present();
    @(negedge clk) reset = 1'b1;

    // Program load with execution disabled
    for (int i = 0; i < 8; i++) begin
      RAM_Write_Address = 3'(i);
      RAM_Write_Data    = prog1[i];
      RAM_Write_Enable  = 1'b1;
      step(1);
    end
    RAM_Write_Enable = 1'b0;
    for (int i = 0; i < 8; i++) expect_val(S_RAM + i, prog1[i], $sformatf("load_ram%0d", i));
    expect_val(S_PC, 11'd0, "load_pc");
    for (int i = 0; i < 4; i++) expect_val(S_R0 + i, 11'd0, $sformatf("load_reg%0d", i));
    present();

    // LD R1,[R2] with R2 supplied by InD
    InE = 1'b1; InD = 5'd7; PC_Enable = 1'b1;
    step(1);
    expect_val(S_R1, 11'd3, "ld_r1");
    expect_val(S_PC, 11'd1, "ld_pc");
    present();

    // Accumulate loop until R0 wraps below R1, then rotate and add
    step(1);  expect_val(S_R0, 11'd7,  "loop_r0_7");  present();
    step(3);  expect_val(S_R0, 11'd14, "loop_r0_14"); present();
    step(3);  expect_val(S_R0, 11'd21, "loop_r0_21"); present();
    step(3);  expect_val(S_R0, 11'd28, "loop_r0_28"); expect_val(S_PC, 11'd2, "loop_pc2"); present();
    step(3);  expect_val(S_R0, 11'd3,  "loop_r0_3");  present();
    step(2);  expect_val(S_PC, 11'd4,  "jg_not_taken_pc"); present();
    step(1);  expect_val(S_R0, 11'd12, "rol_r0"); expect_val(S_PC, 11'd5, "rol_pc"); present();
    step(1);
    expect_val(S_R3, 11'd12, "add_r3");
    expect_val(S_PC, 11'd6, "add_pc");
    expect_val(S_R2, 11'd7, "ine_r2");
    expect_val(S_PI, 11'd0, "pi_at_6");
    present();
    step(1);  expect_val(S_PC, 11'd7, "nop_pc7"); expect_val(S_PI, 11'd3, "pi_at_7"); present();
    step(1);  expect_val(S_PC, 11'd0, "pc_wrap"); present();

    // Asynchronous reset mid-run, checked before any clock edge
    reset = 1'b0;
    #2;
    expect_cleared("midrst");
    present();
    @(negedge clk);
    reset = 1'b1; PC_Enable = 1'b0; InD = 5'd5;

    for (int i = 0; i < 7; i++) begin
      RAM_Write_Address = 3'(i);
      RAM_Write_Data    = prog2[i];
      RAM_Write_Enable  = 1'b1;
      step(1);
    end
    RAM_Write_Enable = 1'b0;
    PC_Enable = 1'b1;

    step(1); expect_val(S_R1, 11'd5, "mov_r1"); expect_val(S_OUT, 11'd0, "out_before"); present();
    step(1); expect_val(S_OUT, 11'd5, "out_r1"); expect_val(S_PC, 11'd2, "out_pc"); present();
    step(1); expect_val(S_RAM, 11'd5, "st_ram0"); expect_val(S_OUT, 11'd5, "out_hold_st"); present();
    step(1); expect_val(S_R1, 11'd18, "ror_r1"); present();
    step(1); expect_val(S_R0, 11'd14, "sub_wrap_r0"); present();
    step(1); expect_val(S_PC, 11'd6, "cmp_pc"); present();
    step(1); expect_val(S_PC, 11'd0, "je_taken_pc"); expect_val(S_OUT, 11'd5, "out_hold_je"); present();
    step(1); expect_val(S_PC, 11'd1, "nop_pc1"); expect_val(S_PI, prog2[1], "pi_out"); present();
    step(1); expect_val(S_OUT, 11'd18, "out_r1_new"); present();
    PC_Enable = 1'b0;

    step(1);
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
